mult_div_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width, serving MULT/MULTU/DIV/DIVU/MTHI/MTLO in the EX stage of the pipelined datapath. The unit accepts an operation from EX and computes over several cycles. It raises Busy so the hazard logic stalls IF/ID/EX, then updates Hi/Lo and pulses Done. A Flush input aborts an in-flight operation without disturbing Hi/Lo, which lets a mispredicted or squashed instruction be cancelled.

---
 rtl/mult_div_unit_if.sv | 15 +
 rtl/mult_div_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic             o_dbz;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  modport master(output i_start, i_op, i_a, i_b, i_flush, input o_busy, o_done, o_dbz, o_hi, o_lo);
  modport slave(input i_start, i_op, i_a, i_b, i_flush, output o_busy, o_done, o_dbz, o_hi, o_lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide on magnitudes with HI/LO registers.
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     rst,
  mult_div_if.slave s
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_div, r_neg_q, r_neg_r, r_zero, r_busy, r_done, r_dbz;
  logic               w_sgn, w_md;
  logic [WIDTH-1:0]   w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  always_comb begin
    w_sgn  = ~s.i_op[0];
    w_md   = ~s.i_op[2];
    w_ma   = (w_sgn && s.i_a[WIDTH-1]) ? -s.i_a : s.i_a;
    w_mb   = (w_sgn && s.i_b[WIDTH-1]) ? -s.i_b : s.i_b;
    w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff = w_sh - {1'b0, r_m};
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end
  // multiply keeps |A| in r_m and shifts |B| out of the low half; divide keeps |B| in r_m
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: if (s.i_start && !s.i_flush) begin
          if (w_md) begin
            r_div   <= s.i_op[1];
            r_m     <= s.i_op[1] ? w_mb : w_ma;
            r_acc   <= {{WIDTH{1'b0}}, s.i_op[1] ? w_ma : w_mb};
            r_neg_q <= w_sgn && (s.i_a[WIDTH-1] ^ s.i_b[WIDTH-1]);
            r_neg_r <= w_sgn && s.i_a[WIDTH-1];
            r_zero  <= s.i_op[1] && s.i_b == '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= (s.i_op[1] && s.i_b == '0) ? FIX : RUN;
            r_busy  <= 1'b1;
          end else if (!s.i_op[1]) begin
            if (s.i_op[0]) r_lo <= s.i_a;
            else r_hi <= s.i_a;
          end
        end
        RUN: if (s.i_flush) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_acc   <= !r_div ? {w_sum, r_acc[WIDTH-1:1]} :
                     !w_diff[WIDTH] ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1} :
                     {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt - CW'(1);
          r_state <= (r_cnt == CW'(1)) ? FIX : RUN;
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!s.i_flush) begin
            r_done <= 1'b1;
            r_dbz  <= r_zero;
            if (!r_zero) begin
              r_hi <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
              r_lo <= r_div ? w_q : w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign s.o_busy = r_busy;
  assign s.o_done = r_done;
  assign s.o_dbz  = r_dbz;
  assign s.o_hi   = r_hi;
  assign s.o_lo   = r_lo;
endmodule
